sram_2168_ctl: RTL and testbench



---
 rtl/sram_2168_ctl.sv | 135 +++++++++++++
 tb/tb_sram_2168_ctl.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2168_ctl.sv
// Single-word req/ack controller for a 4K x 16 bank of 2168 SRAMs (two byte lanes).
// Sequences A/CE_n/WE_n/data-enable with all SRAM-side outputs registered.
module sram_2168_ctl #(
   parameter int ADDR_W   = 12,
   parameter int DATA_W   = 16,
   parameter int RD_WAIT  = 2,
   parameter int WR_SETUP = 1,
   parameter int WR_PULSE = 2,
   parameter int WR_HOLD  = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [1:0]        be,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ack,
   output logic              busy,
   output logic [ADDR_W-1:0] sram_a,
   output logic              sram_ce_n,
   output logic [1:0]        sram_we_n,
   output logic [DATA_W-1:0] sram_d_out,
   output logic              sram_d_oe,
   input  logic [DATA_W-1:0] sram_d_in
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_WSU  = 3'd2;
   localparam logic [2:0] S_WPL  = 3'd3;
   localparam logic [2:0] S_WHD  = 3'd4;
   localparam logic [2:0] S_ACK  = 3'd5;

   localparam logic [3:0] RD_CNT    = 4'(RD_WAIT);
   localparam logic [3:0] SETUP_CNT = 4'(WR_SETUP - 1);
   localparam logic [3:0] PULSE_CNT = 4'(WR_PULSE - 1);
   localparam logic [3:0] HOLD_CNT  = 4'((WR_HOLD > 0) ? (WR_HOLD - 1) : 0);

   logic [2:0] state;
   logic [3:0] cnt;
   logic [1:0] be_q;

   assign busy = (state != S_IDLE);

   // Address and write data are loaded only on acceptance, so they stay frozen
   // for the whole WE_n-low window where the 2168 would latch any change.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         be_q       <= 2'b00;
         ack        <= 1'b0;
         rdata      <= '0;
         sram_a     <= '0;
         sram_ce_n  <= 1'b1;
         sram_we_n  <= 2'b11;
         sram_d_out <= '0;
         sram_d_oe  <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  sram_a     <= addr;
                  sram_d_out <= wdata;
                  be_q       <= be;
                  sram_ce_n  <= 1'b0;
                  if (we) begin
                     state     <= S_WSU;
                     cnt       <= SETUP_CNT;
                     sram_d_oe <= 1'b1;
                  end else begin
                     state <= S_RD;
                     cnt   <= RD_CNT;
                  end
               end
            end
            S_RD: begin
               if (cnt == 4'd0) begin
                  rdata     <= sram_d_in;
                  sram_ce_n <= 1'b1;
                  ack       <= 1'b1;
                  state     <= S_ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_WSU: begin
               if (cnt == 4'd0) begin
                  sram_we_n <= ~be_q;
                  cnt       <= PULSE_CNT;
                  state     <= S_WPL;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_WPL: begin
               if (cnt == 4'd0) begin
                  sram_we_n <= 2'b11;
                  if (WR_HOLD == 0) begin
                     sram_ce_n <= 1'b1;
                     sram_d_oe <= 1'b0;
                     ack       <= 1'b1;
                     state     <= S_ACK;
                  end else begin
                     cnt   <= HOLD_CNT;
                     state <= S_WHD;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_WHD: begin
               if (cnt == 4'd0) begin
                  sram_ce_n <= 1'b1;
                  sram_d_oe <= 1'b0;
                  ack       <= 1'b1;
                  state     <= S_ACK;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_ACK: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_2168_ctl.sv
// Directed bench for sram_2168_ctl: default-timing instance plus a RD_WAIT=0/WR_HOLD=0 instance,
// each backed by a simple behavioural 2168 bank.
module tb_sram_2168_ctl;

   logic clk;
   logic reset;

   logic        req0, we0, ack0, busy0, ce0, doe0;
   logic [11:0] addr0, sa0;
   logic [1:0]  be0, wen0;
   logic [15:0] wdata0, rdata0, dout0, din0;

   logic        req1, we1, ack1, busy1, ce1, doe1;
   logic [11:0] addr1, sa1;
   logic [1:0]  be1, wen1;
   logic [15:0] wdata1, rdata1, dout1, din1;

   logic [15:0] mem0 [0:4095];
   logic [15:0] mem1 [0:4095];

   int errors;
   int checks;

   int          lat;
   logic [15:0] rd_val;
   logic [1:0]  we_tr   [0:41];
   logic        oe_tr   [0:41];
   logic        ce_tr   [0:41];
   logic        busy_tr [0:41];
   bit          a_bad, oe_any, we_any, inv_bad;

   sram_2168_ctl dut0 (
      .clk(clk), .reset(reset), .req(req0), .we(we0), .addr(addr0), .be(be0),
      .wdata(wdata0), .rdata(rdata0), .ack(ack0), .busy(busy0), .sram_a(sa0),
      .sram_ce_n(ce0), .sram_we_n(wen0), .sram_d_out(dout0), .sram_d_oe(doe0),
      .sram_d_in(din0)
   );

   sram_2168_ctl #(.RD_WAIT(0), .WR_HOLD(0)) dut1 (
      .clk(clk), .reset(reset), .req(req1), .we(we1), .addr(addr1), .be(be1),
      .wdata(wdata1), .rdata(rdata1), .ack(ack1), .busy(busy1), .sram_a(sa1),
      .sram_ce_n(ce1), .sram_we_n(wen1), .sram_d_out(dout1), .sram_d_oe(doe1),
      .sram_d_in(din1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural SRAM banks: a lane is written while CE_n and its WE_n are low.
   assign din0 = ce0 ? 16'h0000 : mem0[sa0];
   assign din1 = ce1 ? 16'h0000 : mem1[sa1];

   always @(posedge clk) begin
      if (!ce0 && !wen0[0]) mem0[sa0][7:0]  <= doe0 ? dout0[7:0]  : 8'h00;
      if (!ce0 && !wen0[1]) mem0[sa0][15:8] <= doe0 ? dout0[15:8] : 8'h00;
      if (!ce1 && !wen1[0]) mem1[sa1][7:0]  <= doe1 ? dout1[7:0]  : 8'h00;
      if (!ce1 && !wen1[1]) mem1[sa1][15:8] <= doe1 ? dout1[15:8] : 8'h00;
   end

   // Drives one request from the current negedge and traces the SRAM pins each
   // following cycle until ack; cycle 1 is the cycle after the accepting edge.
   task automatic do_txn(input int inst, input logic w, input logic [11:0] a,
                         input logic [15:0] d, input logic [1:0] b, input bit keep);
      logic [1:0]  o_we;
      logic        o_oe, o_ce, o_busy, o_ack;
      logic [11:0] o_a;
      lat = -1; a_bad = 0; oe_any = 0; we_any = 0; inv_bad = 0; rd_val = 16'h0;
      if (inst == 0) begin
         req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; be0 = b;
      end else begin
         req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; be1 = b;
      end
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         o_we   = (inst == 0) ? wen0  : wen1;
         o_oe   = (inst == 0) ? doe0  : doe1;
         o_ce   = (inst == 0) ? ce0   : ce1;
         o_busy = (inst == 0) ? busy0 : busy1;
         o_ack  = (inst == 0) ? ack0  : ack1;
         o_a    = (inst == 0) ? sa0   : sa1;
         we_tr[c] = o_we; oe_tr[c] = o_oe; ce_tr[c] = o_ce; busy_tr[c] = o_busy;
         if (o_busy && o_a !== a) a_bad = 1;
         if (o_oe) oe_any = 1;
         if (o_we != 2'b11) begin
            we_any = 1;
            if (o_ce !== 1'b0 || o_oe !== 1'b1) inv_bad = 1;
         end
         if (o_ack) begin
            lat = c;
            rd_val = (inst == 0) ? rdata0 : rdata1;
            break;
         end
      end
      if (!keep || lat < 0) begin
         if (inst == 0) req0 = 1'b0; else req1 = 1'b0;
      end
   endtask

   task automatic test_reset();
      checks++;
      if ({ack0, busy0, ce0, wen0, doe0} !== 6'b0_0_1_11_0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl: got %b expected 001110", {ack0, busy0, ce0, wen0, doe0});
      end
      checks++;
      if ({rdata0, sa0, dout0} !== 44'h0) begin
         errors++;
         $display("[TB] FAIL reset_data: got rdata=%h a=%h dout=%h expected zeros", rdata0, sa0, dout0);
      end
      checks++;
      if ({ack1, busy1, ce1, wen1, doe1} !== 6'b0_0_1_11_0) begin
         errors++;
         $display("[TB] FAIL reset_ctrl_fast: got %b expected 001110", {ack1, busy1, ce1, wen1, doe1});
      end
   endtask

   task automatic test_write_read();
      do_txn(0, 1'b1, 12'h123, 16'hBEEF, 2'b11, 0);
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("[TB] FAIL wr_latency: got %0d expected 5", lat);
      end
      checks++;
      if ({we_tr[1], we_tr[2], we_tr[3], we_tr[4], we_tr[5]} !== 10'b11_00_00_11_11) begin
         errors++;
         $display("[TB] FAIL wr_we_trace: got %b expected 1100001111",
                  {we_tr[1], we_tr[2], we_tr[3], we_tr[4], we_tr[5]});
      end
      checks++;
      if ({oe_tr[1], oe_tr[2], oe_tr[3], oe_tr[4], oe_tr[5]} !== 5'b11110) begin
         errors++;
         $display("[TB] FAIL wr_oe_trace: got %b expected 11110",
                  {oe_tr[1], oe_tr[2], oe_tr[3], oe_tr[4], oe_tr[5]});
      end
      checks++;
      if ({ce_tr[1], ce_tr[2], ce_tr[3], ce_tr[4], ce_tr[5]} !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL wr_ce_trace: got %b expected 00001",
                  {ce_tr[1], ce_tr[2], ce_tr[3], ce_tr[4], ce_tr[5]});
      end
      checks++;
      if ({a_bad, inv_bad} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL wr_stable: got a_bad=%0d inv_bad=%0d expected 0 0", a_bad, inv_bad);
      end
      @(negedge clk);
      checks++;
      if ({ack0, busy0} !== 2'b00) begin
         errors++;
         $display("[TB] FAIL ack_pulse: got ack=%b busy=%b expected 0 0", ack0, busy0);
      end
      do_txn(0, 1'b0, 12'h123, 16'h0000, 2'b00, 0);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL rd_latency: got %0d expected 4", lat);
      end
      checks++;
      if (rd_val !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL rd_data: got %h expected beef", rd_val);
      end
      checks++;
      if ({oe_any, ce_tr[1], ce_tr[3], ce_tr[4]} !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL rd_pins: got oe_any=%0d ce1=%b ce3=%b ce4=%b expected 0 0 0 1",
                  oe_any, ce_tr[1], ce_tr[3], ce_tr[4]);
      end
      @(negedge clk);
      checks++;
      if (rdata0 !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL rd_hold: got %h expected beef", rdata0);
      end
   endtask

   task automatic test_byte_lane();
      do_txn(0, 1'b1, 12'h7FF, 16'hAAAA, 2'b11, 0);
      @(negedge clk);
      do_txn(0, 1'b1, 12'h7FF, 16'h1234, 2'b01, 0);
      checks++;
      if ({we_tr[1], we_tr[2], we_tr[3], we_tr[4]} !== 8'b11_10_10_11 || lat !== 5) begin
         errors++;
         $display("[TB] FAIL lane_we_trace: got %b lat=%0d expected 11101011 lat=5",
                  {we_tr[1], we_tr[2], we_tr[3], we_tr[4]}, lat);
      end
      @(negedge clk);
      do_txn(0, 1'b0, 12'h7FF, 16'h0000, 2'b00, 0);
      checks++;
      if (rd_val !== 16'hAA34) begin
         errors++;
         $display("[TB] FAIL lane_readback: got %h expected aa34", rd_val);
      end
   endtask

   task automatic test_be_zero();
      @(negedge clk);
      do_txn(0, 1'b1, 12'h010, 16'h5A5A, 2'b11, 0);
      @(negedge clk);
      do_txn(0, 1'b1, 12'h010, 16'hFFFF, 2'b00, 0);
      checks++;
      if (lat !== 5 || we_any !== 1'b0) begin
         errors++;
         $display("[TB] FAIL be0_write: got lat=%0d we_low=%0d expected lat=5 we_low=0", lat, we_any);
      end
      @(negedge clk);
      do_txn(0, 1'b0, 12'h010, 16'h0000, 2'b00, 0);
      checks++;
      if (rd_val !== 16'h5A5A) begin
         errors++;
         $display("[TB] FAIL be0_unchanged: got %h expected 5a5a", rd_val);
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      do_txn(0, 1'b1, 12'hFFF, 16'hC3A5, 2'b11, 1);
      checks++;
      if (lat !== 5) begin
         errors++;
         $display("[TB] FAIL b2b_wr_latency: got %0d expected 5", lat);
      end
      do_txn(0, 1'b0, 12'hFFF, 16'h0000, 2'b00, 0);
      checks++;
      if (lat !== 5 || busy_tr[1] !== 1'b0 || busy_tr[2] !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_gap: got lat=%0d busy1=%b busy2=%b expected 5 0 1",
                  lat, busy_tr[1], busy_tr[2]);
      end
      checks++;
      if (rd_val !== 16'hC3A5) begin
         errors++;
         $display("[TB] FAIL b2b_data: got %h expected c3a5", rd_val);
      end
   endtask

   task automatic test_reset_abort();
      bit found;
      bit ack_seen;
      found = 0;
      ack_seen = 0;
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h200; wdata0 = 16'h0F0F; be0 = 2'b11;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (wen0 != 2'b11) begin
            found = 1;
            break;
         end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("[TB] FAIL abort_reach_wpl: got no WE_n pulse expected one within 20 cycles");
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if ({ce0, wen0, doe0, busy0, ack0} !== 6'b1_11_0_0_0) begin
         errors++;
         $display("[TB] FAIL abort_immediate: got %b expected 111000", {ce0, wen0, doe0, busy0, ack0});
      end
      req0 = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         if (ack0) ack_seen = 1;
      end
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (ack0 || busy0) ack_seen = 1;
      end
      checks++;
      if (ack_seen !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_no_ack: got activity=1 expected 0");
      end
      do_txn(0, 1'b0, 12'h123, 16'h0000, 2'b00, 0);
      checks++;
      if (lat !== 4 || rd_val !== 16'hBEEF) begin
         errors++;
         $display("[TB] FAIL abort_recover: got lat=%0d data=%h expected 4 beef", lat, rd_val);
      end
   endtask

   task automatic test_fast_timing();
      @(negedge clk);
      do_txn(1, 1'b1, 12'h055, 16'h1357, 2'b11, 0);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("[TB] FAIL fast_wr_latency: got %0d expected 4", lat);
      end
      checks++;
      if ({we_tr[3], ce_tr[3], oe_tr[3], we_tr[4], ce_tr[4], oe_tr[4]} !== 8'b00_0_1_11_1_0) begin
         errors++;
         $display("[TB] FAIL fast_wr_release: got %b expected 00011110",
                  {we_tr[3], ce_tr[3], oe_tr[3], we_tr[4], ce_tr[4], oe_tr[4]});
      end
      @(negedge clk);
      do_txn(1, 1'b0, 12'h055, 16'h0000, 2'b00, 0);
      checks++;
      if (lat !== 2 || rd_val !== 16'h1357) begin
         errors++;
         $display("[TB] FAIL fast_rd: got lat=%0d data=%h expected 2 1357", lat, rd_val);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset = 1'b1;
      req0 = 1'b0; we0 = 1'b0; addr0 = '0; be0 = '0; wdata0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0; be1 = '0; wdata1 = '0;
      repeat (2) @(negedge clk);
      test_reset();
      reset = 1'b0;
      @(negedge clk);
      test_write_read();
      @(negedge clk);
      test_byte_lane();
      test_be_zero();
      test_back_to_back();
      test_reset_abort();
      test_fast_timing();
      repeat (2) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
